div_sequencer: RTL

- Request/response sequencer placed directly around the integer SRT divider.
- Upstream side: accepts a divide request on a valid/ready handshake, holds the operands stable and drives the divider's reset/start pins.
- Downstream side: detects divider completion and applies remainder-sign and overflow/div-by-zero result conventions.
- Presents the final result on a valid/ready output with backpressure; one operation in flight.

---
 rtl/div_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: request/response wrapper around an SRT divider. Latches the
// operands, pulses the divider's reset and start pins, waits for the rising
// edge of divDone (or a timeout), applies the remainder-sign and exception
// conventions and presents the result on a valid/ready port with backpressure.
module div_sequencer #(
  parameter int N       = 32,
  parameter int TIMEOUT = N + 8
) (
  input  logic         clk,
  input  logic         rstN,
  // request side
  input  logic         reqValid,
  output logic         reqReady,
  input  logic         reqSigned,
  input  logic [N-1:0] reqX,
  input  logic [N-1:0] reqY,
  // divider side
  output logic         divRst,
  output logic         divStart,
  output logic         divSigned,
  output logic [N-1:0] divX,
  output logic [N-1:0] divY,
  input  logic         divDone,
  input  logic [N-1:0] divQ,
  input  logic [N-1:0] divR,
  input  logic         divByZero,
  // result side
  output logic         resValid,
  input  logic         resReady,
  output logic [N-1:0] resQ,
  output logic [N-1:0] resR,
  output logic         resDivByZero,
  output logic         resOverflow,
  output logic         resTimeout
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    GO   = 3'd2,
    WAIT = 3'd3,
    HOLD = 3'd4
  } stateT;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  stateT         state;
  stateT         stateNext;
  logic [CW-1:0] cnt;
  logic          divDonePrev;

  logic          doneEdge;
  logic          cntExpired;
  logic          isOverflow;
  logic [N-1:0]  qCalc;
  logic [N-1:0]  rCalc;

  assign doneEdge   = divDone & ~divDonePrev;
  assign cntExpired = (cnt == CW'(TIMEOUT - 1));
  assign isOverflow = divSigned && (divX == MIN_VAL) && (divY == '1);

  // State register.
  always_ff @(posedge clk or negedge rstN) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of block ordering.
    if (!rstN) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns stateNext and no latch forms.
    stateNext = state;
    unique case (state)
      IDLE:    if (reqValid) stateNext = CLR;
      CLR:     stateNext = GO;
      GO:      stateNext = WAIT;
      WAIT:    if (doneEdge || cntExpired) stateNext = HOLD;
      HOLD:    if (resReady) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Handshake and divider control pins, decoded from the current state.
  always_comb begin
    reqReady = (state == IDLE);
    divRst   = (state == CLR);
    divStart = (state == GO);
    resValid = (state == HOLD);
  end

  // Result conventions: div-by-zero beats overflow beats the normal path.
  // The divider returns a remainder magnitude; it takes the dividend's sign.
  always_comb begin
    if (divByZero) begin
      qCalc = '1;
      rCalc = divX;
    end else if (isOverflow) begin
      qCalc = divX;
      rCalc = '0;
    end else begin
      qCalc = divQ;
      rCalc = (divSigned && divX[N-1]) ? -divR : divR;
    end
  end

  // Operand latch: captured on accept, held until the next accept.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      divX      <= '0;
      divY      <= '0;
      divSigned <= 1'b0;
    end else if (state == IDLE && reqValid) begin
      divX      <= reqX;
      divY      <= reqY;
      divSigned <= reqSigned;
    end
  end

  // WAIT cycle counter and done-edge history. divDonePrev follows divDone in
  // every state: a divider that honours divRst is already low by GO, so this
  // equals clearing it there, while a level stuck high across CLR can never
  // look like a fresh completion.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt         <= '0;
      divDonePrev <= 1'b0;
    end else begin
      divDonePrev <= divDone;
      if (state == GO)        cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CW'(1);
    end
  end

  // Result registers: loaded when WAIT ends, flags dropped on result handshake.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      resQ         <= '0;
      resR         <= '0;
      resDivByZero <= 1'b0;
      resOverflow  <= 1'b0;
      resTimeout   <= 1'b0;
    end else if (state == WAIT && doneEdge) begin
      resQ         <= qCalc;
      resR         <= rCalc;
      resDivByZero <= divByZero;
      resOverflow  <= !divByZero && isOverflow;
      resTimeout   <= 1'b0;
    end else if (state == WAIT && cntExpired) begin
      resQ         <= '0;
      resR         <= '0;
      resDivByZero <= 1'b0;
      resOverflow  <= 1'b0;
      resTimeout   <= 1'b1;
    end else if (state == HOLD && resReady) begin
      resDivByZero <= 1'b0;
      resOverflow  <= 1'b0;
      resTimeout   <= 1'b0;
    end
  end

endmodule
